audio_dac_serializer: RTL

Codec-side serializer sitting directly downstream of the audio effects stage and upstream of the WM8731 pins. It generates the bit clock and LR clock from the audio clock and issues the per-frame `sample_req` pulse the effects stage consumes. It captures the 16-bit sample returned in the following cycle and shifts it out left-justified on both channels. It also deserializes the ADC line into `audio_input` and signals each completed capture with `sample_end`.

---
 rtl/audio_pkg.sv | 24 ++
 rtl/audio_clkgen.sv | 57 +++++
 rtl/audio_dac_serializer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// -----------------------------------------------------------------------------
// audio_pkg
// Shared types and default constants for the WM8731 audio serializer path.
//   sample_t            : one audio sample word
//   AUDIO_DATA_WIDTH    : sample width in bits
//   AUDIO_BCLK_DIV      : clk cycles per bit-clock period
//   AUDIO_SLOT_BITS     : bit-clock periods per channel slot
//   AUDIO_FRAME_CYCLES  : clk cycles per stereo frame
//   frame_cycles()      : frame length for an arbitrary slot/divider choice
// -----------------------------------------------------------------------------
package audio_pkg;

   localparam int AUDIO_DATA_WIDTH   = 16;
   localparam int AUDIO_BCLK_DIV     = 4;
   localparam int AUDIO_SLOT_BITS    = 32;
   localparam int AUDIO_FRAME_CYCLES = 2 * AUDIO_SLOT_BITS * AUDIO_BCLK_DIV;

   typedef logic [15:0] sample_t;

   function automatic int frame_cycles(input int slot_bits, input int bclk_div);
      return 2 * slot_bits * bclk_div;
   endfunction

endpackage

// File: rtl/audio_clkgen.sv
// -----------------------------------------------------------------------------
// audio_clkgen
// Frame phase counter and codec bit/LR clocks.
//   clk, reset_n  : audio clock, asynchronous active-low reset
//   ph            : current frame phase, 0..F-1
//   ph_nxt        : phase that the next clk edge enters
//   bclk_rise     : next edge enters a bit-clock rising phase
//   bclk_fall     : next edge enters a bit-clock falling phase
//   AUD_BCLK      : bit clock (registered)
//   AUD_DACLRCK   : LR clock, 0 = left slot, 1 = right slot (registered)
// -----------------------------------------------------------------------------
module audio_clkgen
   import audio_pkg::*;
#(
   parameter  int BCLK_DIV  = AUDIO_BCLK_DIV,
   parameter  int SLOT_BITS = AUDIO_SLOT_BITS,
   localparam int F         = frame_cycles(SLOT_BITS, BCLK_DIV),
   localparam int PH_W      = $clog2(F)
) (
   input  logic            clk,
   input  logic            reset_n,
   output logic [PH_W-1:0] ph,
   output logic [PH_W-1:0] ph_nxt,
   output logic            bclk_rise,
   output logic            bclk_fall,
   output logic            AUD_BCLK,
   output logic            AUD_DACLRCK
);

   logic bclk_nxt;
   logic lrck_nxt;

   // Everything is decoded from the phase being entered so the clock outputs
   // are registered yet line up exactly with ph.
   always_comb begin
      ph_nxt    = (ph == PH_W'(F - 1)) ? '0 : ph + 1'b1;
      bclk_nxt  = (int'(ph_nxt) % BCLK_DIV) >= (BCLK_DIV / 2);
      bclk_rise = (int'(ph_nxt) % BCLK_DIV) == (BCLK_DIV / 2);
      bclk_fall = (int'(ph_nxt) % BCLK_DIV) == 0;
      lrck_nxt  = int'(ph_nxt) >= (F / 2);
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ph          <= '0;
         AUD_BCLK    <= 1'b0;
         AUD_DACLRCK <= 1'b0;
      end else begin
         ph          <= ph_nxt;
         AUD_BCLK    <= bclk_nxt;
         AUD_DACLRCK <= lrck_nxt;
      end
   end

endmodule

// File: rtl/audio_dac_serializer.sv
// -----------------------------------------------------------------------------
// audio_dac_serializer
// WM8731-side serializer: requests one sample per frame from the effects
// stage, shifts it out left-justified on both slots, and deserializes the
// left ADC slot.
//   clk, reset_n  : audio clock, asynchronous active-low reset
//   sample_in     : sample word, valid in the cycle after sample_req
//   sample_req    : one-cycle request pulse per frame
//   sample_end    : one-cycle pulse, audio_input updated this cycle
//   audio_input   : last captured left-channel ADC word
//   AUD_BCLK      : bit clock
//   AUD_DACLRCK   : LR clock
//   AUD_DACDAT    : serial DAC data
//   AUD_ADCDAT    : serial ADC data
// Build option: define AUDIO_ADC_EN to include the ADC capture path; without
// it audio_input is tied to 0 while sample_end keeps pulsing.
// -----------------------------------------------------------------------------
module audio_dac_serializer
   import audio_pkg::*;
#(
   parameter  int DATA_WIDTH = AUDIO_DATA_WIDTH,
   parameter  int BCLK_DIV   = AUDIO_BCLK_DIV,
   parameter  int SLOT_BITS  = AUDIO_SLOT_BITS,
   localparam int F          = frame_cycles(SLOT_BITS, BCLK_DIV),
   localparam int PH_W       = $clog2(F)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [DATA_WIDTH-1:0] sample_in,
   output logic                  sample_req,
   output logic                  sample_end,
   output logic [DATA_WIDTH-1:0] audio_input,
   output logic                  AUD_BCLK,
   output logic                  AUD_DACLRCK,
   output logic                  AUD_DACDAT,
   input  logic                  AUD_ADCDAT
);

   localparam int HALF   = F / 2;
   localparam int CAP_PH = DATA_WIDTH * BCLK_DIV;
   localparam int IDX_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   logic [PH_W-1:0]       ph;
   logic [PH_W-1:0]       ph_nxt;
   logic                  bclk_rise;
   logic                  bclk_fall;

   logic [DATA_WIDTH-1:0] hold_reg;
   logic [DATA_WIDTH-1:0] shift_reg;
   logic [DATA_WIDTH-1:0] tx_word;
   logic                  tx_bit_nxt;
   logic                  in_data_nxt;
   logic                  left_nxt;
   logic                  cap_nxt;
   int                    k_nxt;

   audio_clkgen #(
      .BCLK_DIV  (BCLK_DIV),
      .SLOT_BITS (SLOT_BITS)
   ) u_clkgen (
      .clk         (clk),
      .reset_n     (reset_n),
      .ph          (ph),
      .ph_nxt      (ph_nxt),
      .bclk_rise   (bclk_rise),
      .bclk_fall   (bclk_fall),
      .AUD_BCLK    (AUD_BCLK),
      .AUD_DACLRCK (AUD_DACLRCK)
   );

   // NOTE: tx_bit_nxt gets a default before the conditional assignment so
   // this block stays purely combinational with no inferred latch.
   always_comb begin
      k_nxt       = (int'(ph_nxt) % HALF) / BCLK_DIV;
      in_data_nxt = k_nxt < DATA_WIDTH;
      left_nxt    = int'(ph_nxt) < HALF;
      cap_nxt     = int'(ph_nxt) == CAP_PH;
      // Entering ph 0 the shift register is reloaded on the same edge, so
      // the MSB has to come straight from the holding register.
      tx_word     = (ph_nxt == '0) ? hold_reg : shift_reg;
      tx_bit_nxt  = 1'b0;
      if (in_data_nxt) begin
         tx_bit_nxt = tx_word[IDX_W'(DATA_WIDTH - 1 - k_nxt)];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hold_reg   <= '0;
         shift_reg  <= '0;
         sample_req <= 1'b0;
         sample_end <= 1'b0;
         AUD_DACDAT <= 1'b0;
      end else begin
         sample_req <= int'(ph_nxt) == (F - 4);
         sample_end <= cap_nxt;
         // The effects stage answers one cycle after the request.
         if (int'(ph) == (F - 3)) begin
            hold_reg <= sample_in;
         end
         if (ph_nxt == '0) begin
            shift_reg <= hold_reg;
         end
         // Data moves only on bclk falling edges; outside the data bits the
         // line idles low. Both slots index the same word.
         if (bclk_fall) begin
            AUD_DACDAT <= tx_bit_nxt;
         end
      end
   end

`ifdef AUDIO_ADC_EN
   logic [DATA_WIDTH-1:0] adc_sr;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         adc_sr      <= '0;
         audio_input <= '0;
      end else begin
         // Sample on bclk rising edges of the left slot, MSB first; the
         // right slot is ignored.
         if (bclk_rise && left_nxt && in_data_nxt) begin
            adc_sr <= {adc_sr[DATA_WIDTH-2:0], AUD_ADCDAT};
         end
         if (cap_nxt) begin
            audio_input <= adc_sr;
         end
      end
   end
`else
   logic unused_adc;

   assign audio_input = '0;
   assign unused_adc  = ^{AUD_ADCDAT, bclk_rise, left_nxt};
`endif

endmodule
